// File: rtl/lutram_pkg.sv
// Shared definitions for the 64-word LUT-RAM controller: state encoding and geometry.
package lutram_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/lutram64_ctrl_if.sv
// User access, response and fill-control signals of lutram64_ctrl.
interface lutram64_ctrl_if
  import lutram_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic              CLR_REQ;
  logic [WIDTH-1:0]  CLR_VAL;
  logic              CLR_BUSY;
  logic              CLR_DONE;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [WIDTH-1:0]  REQ_WDATA;
  logic              RSP_VALID;
  logic [WIDTH-1:0]  RSP_RDATA;

  modport master (
    output CLR_REQ, CLR_VAL, REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  CLR_BUSY, CLR_DONE, REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  CLR_REQ, CLR_VAL, REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output CLR_BUSY, CLR_DONE, REQ_READY, RSP_VALID, RSP_RDATA
  );

endinterface

// File: rtl/RAM64X1S.sv
// Behavioural model of the 64x1 single-port distributed RAM primitive:
// synchronous write on WCLK, asynchronous read; contents are never reset.
module RAM64X1S (
  output logic O,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic A5,
  input  logic D,
  input  logic WCLK,
  input  logic WE
);

  logic [63:0] mem;
  logic [5:0]  addr;

  assign addr = {A5, A4, A3, A2, A1, A0};

  always_ff @(posedge WCLK) begin
    if (WE) mem[addr] <= D;
  end

  assign O = mem[addr];

endmodule

// File: rtl/lutram64_ctrl.sv
// 64-word LUT-RAM with a single-port user access path and a 64-cycle fill
// sequencer (reset-triggered or on request) that owns the array while it runs.
module lutram64_ctrl
  import lutram_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter bit               CLR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] FILL         = {WIDTH{1'b0}}
) (
  input  logic            CLK,
  input  logic            RST,
  lutram64_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  clr_val_q;
  logic              clr_done;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;

  logic              accept;
  logic              rd_accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din;
  logic [WIDTH-1:0]  ram_dout;

  // RST gating keeps READY low in reset even when the reset state is RUN.
  assign bus.REQ_READY = (state == ST_RUN) && !bus.CLR_REQ && !RST;
  assign accept        = bus.REQ_VALID && bus.REQ_READY;
  assign rd_accept     = accept && !bus.REQ_WE;

  // A restart request suppresses the fill write of that cycle; the new fill begins at 0.
  assign ram_we   = !RST && (((state == ST_CLEAR) && !bus.CLR_REQ) || (accept && bus.REQ_WE));
  assign ram_addr = (state == ST_CLEAR) ? cnt : bus.REQ_ADDR;
  assign ram_din  = (state == ST_CLEAR) ? clr_val_q : bus.REQ_WDATA;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    RAM64X1S u_ram (
      .O    (ram_dout[b]),
      .A0   (ram_addr[0]),
      .A1   (ram_addr[1]),
      .A2   (ram_addr[2]),
      .A3   (ram_addr[3]),
      .A4   (ram_addr[4]),
      .A5   (ram_addr[5]),
      .D    (ram_din[b]),
      .WCLK (CLK),
      .WE   (ram_we)
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= CLR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt       <= '0;
      clr_val_q <= FILL;
      clr_done  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      clr_done  <= 1'b0;
      rsp_valid <= rd_accept;
      if (rd_accept) rsp_rdata <= ram_dout;
      if (bus.CLR_REQ) begin
        state     <= ST_CLEAR;
        cnt       <= '0;
        clr_val_q <= bus.CLR_VAL;
      end else if (state == ST_CLEAR) begin
        // Counter holds at the last address instead of wrapping.
        if (cnt == LAST_ADDR) begin
          state    <= ST_RUN;
          clr_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.CLR_BUSY  = (state == ST_CLEAR);
  assign bus.CLR_DONE  = clr_done;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;

endmodule

// File: tb/tb_lutram64_ctrl.sv
// Directed and randomized bench for lutram64_ctrl against an array model.
module tb_lutram64_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lutram64_ctrl_if #(.WIDTH(8)) bus ();

  lutram64_ctrl #(
    .WIDTH        (8),
    .CLR_ON_RESET (1'b1),
    .FILL         (8'hA5)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  mem_m [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.CLR_REQ   = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
  endtask

  task automatic model_fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem_m[i] = v;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b1;
    bus.REQ_ADDR  = a;
    bus.REQ_WDATA = d;
    chk("wr_ready", 64'(bus.REQ_READY), 64'd1);
    tick();
    mem_m[a] = d;
    idle();
    chk("wr_no_rsp", 64'(bus.RSP_VALID), 64'd0);
  endtask

  task automatic do_read(input string tag, input logic [5:0] a);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = a;
    tick();
    idle();
    chk({tag, "_vld"}, 64'(bus.RSP_VALID), 64'd1);
    chk({tag, "_dat"}, 64'(bus.RSP_RDATA), 64'(mem_m[a]));
  endtask

  task automatic start_fill(input logic [7:0] v);
    bus.CLR_REQ = 1'b1;
    bus.CLR_VAL = v;
    tick();
    bus.CLR_REQ = 1'b0;
  endtask

  // Counts busy observations until the block leaves CLEAR, plus CLR_DONE pulses
  // seen during the fill, in the first RUN cycle and in the cycle after it.
  task automatic run_fill(output int busy, output int dones, output logic rdy_done);
    int guard = 0;
    busy = 0;
    dones = 0;
    while (bus.CLR_BUSY === 1'b1 && guard < 200) begin
      busy++;
      if (bus.CLR_DONE === 1'b1) dones++;
      tick();
      guard++;
    end
    if (bus.CLR_DONE === 1'b1) dones++;
    rdy_done = bus.CLR_DONE & bus.REQ_READY;
    tick();
    if (bus.CLR_DONE === 1'b1) dones++;
  endtask

  initial begin
    int busy, dones, pre;
    logic rdy;
    logic [7:0] v, d, exp_d;
    logic [5:0] a;
    int op;

    idle();
    bus.CLR_VAL   = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;

    // Reset values
    repeat (3) tick();
    bus.REQ_VALID = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.REQ_READY), 64'd0);
    chk("rst_done", 64'(bus.CLR_DONE), 64'd0);
    chk("rst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("rst_rsp_data", 64'(bus.RSP_RDATA), 64'd0);
    chk("rst_busy", 64'(bus.CLR_BUSY), 64'd1);
    idle();
    tick();
    rst = 1'b0;

    // Reset-triggered fill with A5
    run_fill(busy, dones, rdy);
    chk("init_busy_cycles", 64'(busy), 64'd64);
    chk("init_done_pulses", 64'(dones), 64'd1);
    chk("init_ready_at_done", 64'(rdy), 64'd1);
    model_fill(8'hA5);
    do_read("init_rd0", 6'd0);
    do_read("init_rd37", 6'd37);
    do_read("init_rd63", 6'd63);

    // Write then read same address next cycle
    do_write(6'd5, 8'h3C);
    do_read("wr_rd5", 6'd5);

    // Four writes then back-to-back reads
    for (int i = 0; i < 4; i++) do_write(6'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_WE    = 1'b0;
      bus.REQ_ADDR  = 6'(i);
      tick();
      chk("b2b_vld", 64'(bus.RSP_VALID), 64'd1);
      chk("b2b_dat", 64'(bus.RSP_RDATA), 64'(i + 1));
    end
    idle();
    tick();
    chk("b2b_end_vld", 64'(bus.RSP_VALID), 64'd0);

    // CLR_REQ collides with a write: write dropped, user traffic blocked in CLEAR
    v = 8'($urandom);
    if (v == 8'h11) v = 8'h22;
    bus.CLR_REQ   = 1'b1;
    bus.CLR_VAL   = v;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b1;
    bus.REQ_ADDR  = 6'd2;
    bus.REQ_WDATA = 8'h11;
    #1;
    chk("collide_ready", 64'(bus.REQ_READY), 64'd0);
    tick();
    bus.CLR_REQ = 1'b0;
    bus.REQ_ADDR = 6'd40;
    for (int i = 0; i < 10; i++) begin
      bus.REQ_WDATA = 8'($urandom);
      #1;
      if (i == 5) chk("clear_ready", 64'(bus.REQ_READY), 64'd0);
      tick();
    end
    idle();
    run_fill(busy, dones, rdy);
    chk("collide_busy_cycles", 64'(busy + 10), 64'd64);
    chk("collide_done_pulses", 64'(dones), 64'd1);
    model_fill(v);
    do_read("collide_rd2", 6'd2);
    do_read("collide_rd40", 6'd40);

    // Restart fill mid-way: FF then 00 at counter 20
    start_fill(8'hFF);
    pre = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.CLR_DONE === 1'b1) pre++;
      tick();
    end
    start_fill(8'h00);
    run_fill(busy, dones, rdy);
    chk("restart_busy_cycles", 64'(busy), 64'd64);
    chk("restart_done_pulses", 64'(pre + dones), 64'd1);
    model_fill(8'h00);
    for (int i = 0; i < 64; i++) do_read("restart_rd", 6'(i));

    // Asynchronous reset at counter 30 of a fill
    start_fill(8'h5C);
    repeat (30) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("arst_done", 64'(bus.CLR_DONE), 64'd0);
    chk("arst_ready", 64'(bus.REQ_READY), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    run_fill(busy, dones, rdy);
    chk("arst_busy_cycles", 64'(busy), 64'd64);
    chk("arst_done_pulses", 64'(dones), 64'd1);
    model_fill(8'hA5);
    do_read("arst_rd0", 6'd0);
    do_read("arst_rd45", 6'd45);

    // Randomized traffic against the array model
    for (int k = 0; k < 400; k++) begin
      op = int'($urandom_range(0, 2));
      a  = 6'($urandom_range(0, 63));
      d  = 8'($urandom);
      bus.REQ_VALID = (op != 0);
      bus.REQ_WE    = (op == 2);
      bus.REQ_ADDR  = a;
      bus.REQ_WDATA = d;
      exp_d = mem_m[a];
      tick();
      if (op == 2) mem_m[a] = d;
      chk("rnd_vld", 64'(bus.RSP_VALID), 64'(op == 1));
      if (op == 1) chk("rnd_dat", 64'(bus.RSP_RDATA), 64'(exp_d));
    end
    idle();
    tick();

    // Random-value fill, then spot reads
    v = 8'($urandom);
    start_fill(v);
    run_fill(busy, dones, rdy);
    chk("rnd_fill_busy", 64'(busy), 64'd64);
    model_fill(v);
    for (int i = 0; i < 8; i++) do_read("rnd_fill_rd", 6'($urandom_range(0, 63)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
